// File: rtl/tinyml_quant_pkg.sv
// Shared fixed-point types and limits for the int8 quantizer/dequantizer stages.
package tinyml_quant_pkg;

  localparam int unsigned Q824_FRAC_BITS = 24;

  typedef logic signed [7:0]  int8_t;
  typedef logic        [31:0] scale_q824_t;
  typedef logic signed [31:0] acc32_t;
  typedef logic signed [41:0] prod_t;

  localparam acc32_t INT32_MAX = 32'sh7FFF_FFFF;
  localparam acc32_t INT32_MIN = 32'sh8000_0000;

endpackage

// File: rtl/dequant_round_sat.sv
// Combinational round-half-up right shift by S followed by int32 saturation.
module dequant_round_sat
  import tinyml_quant_pkg::*;
#(
  parameter int unsigned S = 24
) (
  input  prod_t  prod,
  output acc32_t result,
  output logic   sat
);

  // One guard bit above the product so adding the rounding constant cannot wrap.
  logic signed [42:0] rounded;

  localparam logic signed [42:0] Max = 43'(INT32_MAX);
  localparam logic signed [42:0] Min = 43'(INT32_MIN);

  generate
    if (S > 0) begin : g_round
      localparam logic signed [42:0] Half = 43'sd1 <<< (S - 1);
      assign rounded = ($signed({prod[41], prod}) + Half) >>> S;
    end else begin : g_pass
      assign rounded = 43'(prod);
    end
  endgenerate

  always_comb begin
    result = rounded[31:0];
    sat    = 1'b0;
    if (rounded > Max) begin
      result = INT32_MAX;
      sat    = 1'b1;
    end else if (rounded < Min) begin
      result = INT32_MIN;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/dequantizer_pipeline.sv
// Streaming int8 -> int32 dequantizer: out = round((x - zp) * scale), scale in Q8.24.
// Define DEQUANT_SAT_COUNT_EN to add the saturation counter and sticky flag.
module dequantizer_pipeline
  import tinyml_quant_pkg::*;
#(
  parameter int unsigned OUT_FRAC_BITS = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [7:0]  in_zero_point,
  input  logic [31:0] in_scale,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_sat
`ifdef DEQUANT_SAT_COUNT_EN
  ,
  input  logic        sat_clr,
  output logic [15:0] sat_count,
  output logic        sat_sticky
`endif
);

  localparam int unsigned Shift = Q824_FRAC_BITS - OUT_FRAC_BITS;

  logic advance;

  logic        s1_valid_q;
  int8_t       s1_x_q;
  int8_t       s1_zp_q;
  scale_q824_t s1_scale_q;

  logic               s2_valid_q;
  logic signed [8:0]  s2_diff_q;
  scale_q824_t        s2_scale_q;

  logic  s3_valid_q;
  prod_t s3_prod_q;

  logic signed [8:0] diff_d;
  prod_t             prod_d;
  acc32_t            rs_result;
  logic              rs_sat;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign diff_d = $signed({s1_x_q[7], s1_x_q}) - $signed({s1_zp_q[7], s1_zp_q});
  // The multiply gets its own register stage so the 9x33 product is not chained with rounding.
  assign prod_d = prod_t'(s2_diff_q) * prod_t'($signed({1'b0, s2_scale_q}));

  dequant_round_sat #(
    .S(Shift)
  ) u_round_sat (
    .prod  (s3_prod_q),
    .result(rs_result),
    .sat   (rs_sat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
    end else if (advance) begin
      s1_valid_q <= in_valid;
      s1_x_q     <= int8_t'(in_data);
      s1_zp_q    <= int8_t'(in_zero_point);
      s1_scale_q <= in_scale;
      s2_valid_q <= s1_valid_q;
      s2_diff_q  <= diff_d;
      s2_scale_q <= s1_scale_q;
      s3_valid_q <= s2_valid_q;
      s3_prod_q  <= prod_d;
      out_valid  <= s3_valid_q;
      if (s3_valid_q) begin
        out_data <= rs_result;
        out_sat  <= rs_sat;
      end
    end
  end

`ifdef DEQUANT_SAT_COUNT_EN
  logic sat_inc;

  assign sat_inc = out_valid && out_ready && out_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count  <= '0;
      sat_sticky <= 1'b0;
    end else if (sat_clr) begin
      sat_count  <= sat_inc ? 16'd1 : 16'd0;
      sat_sticky <= sat_inc;
    end else if (sat_inc) begin
      if (sat_count != 16'hFFFF) begin
        sat_count <= sat_count + 16'd1;
      end
      sat_sticky <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dequantizer_pipeline.sv
// Scoreboard bench: instance 0 uses OUT_FRAC_BITS=0, instance 1 uses OUT_FRAC_BITS=16.
module tb_dequantizer_pipeline;

  typedef struct {
    logic [31:0] data;
    logic        sat;
    int          acc;
    bit          chk_lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid      [2];
  logic        in_ready      [2];
  logic [7:0]  in_data       [2];
  logic [7:0]  in_zero_point [2];
  logic [31:0] in_scale      [2];
  logic        out_valid     [2];
  logic        out_ready     [2];
  logic [31:0] out_data      [2];
  logic        out_sat       [2];
`ifdef DEQUANT_SAT_COUNT_EN
  logic        sat_clr       [2];
  logic [15:0] sat_count     [2];
  logic        sat_sticky    [2];
`endif

  exp_t exp_q [2][$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  logic        stalled   [2];
  logic [31:0] held_data [2];
  logic        held_sat  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dequantizer_pipeline #(
    .OUT_FRAC_BITS(0)
  ) dut0 (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid[0]),
    .in_ready     (in_ready[0]),
    .in_data      (in_data[0]),
    .in_zero_point(in_zero_point[0]),
    .in_scale     (in_scale[0]),
    .out_valid    (out_valid[0]),
    .out_ready    (out_ready[0]),
    .out_data     (out_data[0]),
    .out_sat      (out_sat[0])
`ifdef DEQUANT_SAT_COUNT_EN
    ,
    .sat_clr      (sat_clr[0]),
    .sat_count    (sat_count[0]),
    .sat_sticky   (sat_sticky[0])
`endif
  );

  dequantizer_pipeline #(
    .OUT_FRAC_BITS(16)
  ) dut16 (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid[1]),
    .in_ready     (in_ready[1]),
    .in_data      (in_data[1]),
    .in_zero_point(in_zero_point[1]),
    .in_scale     (in_scale[1]),
    .out_valid    (out_valid[1]),
    .out_ready    (out_ready[1]),
    .out_data     (out_data[1]),
    .out_sat      (out_sat[1])
`ifdef DEQUANT_SAT_COUNT_EN
    ,
    .sat_clr      (sat_clr[1]),
    .sat_count    (sat_count[1]),
    .sat_sticky   (sat_sticky[1])
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every downstream handshake.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        stalled[d] = 1'b0;
      end else begin
        if (out_valid[d] && !out_ready[d]) begin
          chk($sformatf("stall_in_ready%0d", d), 32'(in_ready[d]), 32'd0);
          if (stalled[d]) begin
            chk($sformatf("stall_data_stable%0d", d), out_data[d], held_data[d]);
            chk($sformatf("stall_sat_stable%0d", d), 32'(out_sat[d]), 32'(held_sat[d]));
          end
          stalled[d]   = 1'b1;
          held_data[d] = out_data[d];
          held_sat[d]  = out_sat[d];
        end else begin
          stalled[d] = 1'b0;
        end
        if (out_valid[d] && out_ready[d]) begin
          if (exp_q[d].size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_beat%0d: got data %h, expected no beat", d, out_data[d]);
          end else begin
            exp_t e;
            e = exp_q[d].pop_front();
            chk($sformatf("data%0d", d), out_data[d], e.data);
            chk($sformatf("sat%0d", d), 32'(out_sat[d]), 32'(e.sat));
            if (e.chk_lat) chk($sformatf("latency%0d", d), 32'(cyc - e.acc), 32'd3);
          end
        end
      end
    end
  end

  // Called at posedge+1; leaves in_valid asserted so calls can run back to back.
  task automatic send(input int d, input logic [7:0] x, input logic [7:0] zp,
                      input logic [31:0] sc, input logic [31:0] ed, input logic es,
                      input bit chk_lat);
    bit   ok;
    int   guard;
    exp_t e;
    in_valid[d]      = 1'b1;
    in_data[d]       = x;
    in_zero_point[d] = zp;
    in_scale[d]      = sc;
    ok    = 1'b0;
    guard = 0;
    while (!ok) begin
      @(negedge clk);
      if (in_ready[d] && !reset) begin
        ok        = 1'b1;
        e.data    = ed;
        e.sat     = es;
        e.acc     = cyc + 1;
        e.chk_lat = chk_lat;
        exp_q[d].push_back(e);
      end
      @(posedge clk);
      #1;
      guard++;
      if (!ok && guard > 100) begin
        $display("FAIL send_timeout%0d: in_ready stuck low, expected accept", d);
        $fatal(1, "send timeout");
      end
    end
  endtask

  task automatic idle(input int d);
    in_valid[d] = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("drain_pending", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
  endtask

  localparam logic [31:0] One = 32'h0100_0000;

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]      = 1'b0;
      in_data[d]       = '0;
      in_zero_point[d] = '0;
      in_scale[d]      = '0;
      out_ready[d]     = 1'b1;
      stalled[d]       = 1'b0;
`ifdef DEQUANT_SAT_COUNT_EN
      sat_clr[d]       = 1'b0;
`endif
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_out_valid", 32'(out_valid[d]), 32'd0);
      chk("rst_out_data", out_data[d], 32'd0);
      chk("rst_out_sat", 32'(out_sat[d]), 32'd0);
      chk("rst_in_ready", 32'(in_ready[d]), 32'd1);
    end
    @(posedge clk);
    #1;

    // Unity scale and half-scale rounding at F=0.
    send(0, 8'd10, 8'd0, One, 32'd10, 1'b0, 1'b1);
    idle(0);
    drain();
    send(0, 8'd1, 8'd0, 32'h0080_0000, 32'd1, 1'b0, 1'b1);
    send(0, 8'hFF, 8'd0, 32'h0080_0000, 32'd0, 1'b0, 1'b1);
    send(0, 8'h80, 8'd127, 32'h0080_0000, 32'hFFFF_FF81, 1'b0, 1'b1);
    send(0, 8'd3, 8'd0, 32'h0040_0000, 32'd1, 1'b0, 1'b1);
    send(0, 8'd55, 8'hEC, 32'd0, 32'd0, 1'b0, 1'b1);
    idle(0);
    drain();

    // F=16: saturation both ways, plus in-range values incl. -4.5 rounding to -4.
    send(1, 8'd127, 8'h80, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b1);
    send(1, 8'h80, 8'd127, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
    send(1, 8'd2, 8'd0, One, 32'h0002_0000, 1'b0, 1'b1);
    send(1, 8'hFD, 8'd0, 32'h0000_0180, 32'hFFFF_FFFC, 1'b0, 1'b1);
    idle(1);
    drain();

    // Backpressure: 5 stalled cycles in the middle of an 8-beat stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 8'(i), 8'd0, One, 32'(i), 1'b0, 1'b0);
        idle(0);
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    drain();

    // Reset with three beats in flight; none may emerge afterwards.
    send(0, 8'd20, 8'd0, One, 32'd20, 1'b0, 1'b0);
    send(0, 8'd21, 8'd0, One, 32'd21, 1'b0, 1'b0);
    send(0, 8'd22, 8'd0, One, 32'd22, 1'b0, 1'b0);
    idle(0);
    reset = 1'b1;
    exp_q[0].delete();
    exp_q[1].delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready[0]), 32'd1);
    repeat (6) begin
      @(negedge clk);
      chk("no_stale_beat", 32'(out_valid[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    send(0, 8'hFB, 8'd3, One, 32'hFFFF_FFF8, 1'b0, 1'b1);
    idle(0);
    drain();

`ifdef DEQUANT_SAT_COUNT_EN
    begin
      int guard;
      sat_clr[1] = 1'b1;
      @(posedge clk);
      #1;
      sat_clr[1] = 1'b0;
      chk("cnt_cleared", 32'(sat_count[1]), 32'd0);
      chk("sticky_cleared", 32'(sat_sticky[1]), 32'd0);
      for (int i = 0; i < 3; i++) send(1, 8'd127, 8'h80, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1, 1'b0);
      idle(1);
      drain();
      chk("cnt_three", 32'(sat_count[1]), 32'd3);
      chk("sticky_set", 32'(sat_sticky[1]), 32'd1);
      out_ready[1] = 1'b0;
      send(1, 8'h80, 8'd127, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0);
      idle(1);
      guard = 0;
      while (!out_valid[1] && guard < 20) begin
        @(posedge clk);
        #1;
        guard++;
      end
      chk("fourth_beat_present", 32'(out_valid[1]), 32'd1);
      sat_clr[1]   = 1'b1;
      out_ready[1] = 1'b1;
      @(posedge clk);
      #1;
      sat_clr[1] = 1'b0;
      chk("cnt_clr_plus_inc", 32'(sat_count[1]), 32'd1);
      chk("sticky_clr_plus_inc", 32'(sat_sticky[1]), 32'd1);
      drain();
    end
`endif

    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dequantizer_pipeline.md
Name: dequantizer_pipeline

Overview:
Streaming int8 → int32 dequantizer, the inverse of the accelerator's int32 → int8 quantizer stage. Computes out = round((x − zero_point) × scale), with scale in Q8.24 and a selectable number of fractional bits on the output. It feeds int8 activations and weights back into int32/fixed-point accumulator paths. Three-stage pipeline with valid/ready backpressure.

Parameters:
OUT_FRAC_BITS, 0, fractional bits of out_data (Q(32−F).F), legal range 0..24; shift S = 24 − OUT_FRAC_BITS.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid && in_ready
in_data  in  8  signed int8 value x
in_zero_point  in  8  signed int8 zero point, sampled with each beat
in_scale  in  32  unsigned Q8.24 scale, sampled with each beat
out_valid  out  1  output beat valid
out_ready  in  1  downstream ready
out_data  out  32  signed result
out_sat  out  1  this beat was saturated; qualified by out_valid

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset.
- Reset values: out_valid=0, out_data=0, out_sat=0, all internal stage valids=0.
- Stall rule: advance = !out_valid || out_ready. in_ready = advance, combinational. All three stages move together on advance and hold on !advance.
- S1 (on accept): register x, zp, scale.
- S2: diff = x − zp as 9-bit signed, range [−255,255]. prod = diff × {1'b0,scale}, 42-bit signed. No truncation.
- S3, output register:
  - If S>0: r = (prod + (1<<(S−1))) >>> S. This is round-half-up toward +inf; −0.5 rounds to 0.
  - If S=0: r = prod.
  - Saturate r to [−2^31, 2^31−1]. out_sat=1 when clamped.
- Latency: a beat accepted at edge k is presented at edge k+3 when there is no stall. Throughput is 1 beat/cycle.
- Under backpressure: out_data and out_sat are held stable while out_valid && !out_ready. No beat is lost or duplicated, and order is preserved.
- Bubbles: an invalid stage advances as a bubble and does not block an upstream valid beat.
- Reset mid-operation: all in-flight beats are discarded. out_valid=0 on the cycle after reset is sampled. in_ready=1 once reset deasserts.
- Reset held: in_ready may read 1, but no beat is accepted while reset=1.
- Boundaries:
  - x=−128, zp=127 gives diff=−255.
  - scale=0 gives out_data=0.
  - scale=0xFFFF_FFFF with OUT_FRAC_BITS ≥ 16 must saturate.

Optional Feature:
- Macro: DEQUANT_SAT_COUNT_EN.
- Defined:
  - Adds inputs sat_clr (1) and outputs sat_count (16) and sat_sticky (1).
  - sat_count increments when a beat with out_sat=1 is accepted downstream (out_valid && out_ready). It saturates at 0xFFFF.
  - sat_sticky is set on the same event.
  - Both are cleared by reset or by sat_clr. If sat_clr and an increment occur in the same cycle, the result is count=1, sticky=1.
- Undefined: these ports and their logic are absent. Datapath behaviour is identical in both builds.

Decomposition:
- Package tinyml_quant_pkg:
  - Q824_FRAC_BITS=24, INT32_MAX, INT32_MIN.
  - Typedefs: int8_t (logic signed [7:0]), scale_q824_t (logic [31:0]), acc32_t (logic signed [31:0]), prod_t (logic signed [41:0]).
  - Shared with the quantizer.
- Sub-module dequant_round_sat: combinational shift/round/saturate of prod_t → acc32_t plus a sat flag, parameterised by S. It is reused by the S3 register.

Test Plan:
1. F=0: x=10, zp=0, scale=0x0100_0000 → out_data=10 exactly 3 cycles after accept; out_sat=0.
2. F=0, rounding, scale=0x0080_0000 (0.5):
   - x=1, zp=0 → 1.
   - x=−1, zp=0 → 0.
   - x=−128, zp=127 → −127.
   - With scale=0x0040_0000: x=3 → 1.
3. F=16 saturation, scale=0xFFFF_FFFF:
   - x=127, zp=−128 → 0x7FFF_FFFF, out_sat=1.
   - x=−128, zp=127 → 0x8000_0000, out_sat=1.
4. Backpressure:
   - Stream 8 back-to-back beats x=0..7 (zp=0, scale=1.0), and hold out_ready=0 for 5 cycles mid-stream.
   - Required: outputs 0..7 in order with no drops or duplicates.
   - Required: out_data is stable while stalled, and in_ready=0 while out_valid && !out_ready.
5. Reset mid-stream: assert reset for 1 cycle with 3 beats in flight → out_valid=0 the next cycle and no stale beats afterwards; the next beat accepted after release emerges 3 cycles later.
6. DEQUANT_SAT_COUNT_EN:
   - Drive 3 saturating beats → sat_count=3, sat_sticky=1.
   - Assert sat_clr in the same cycle as a 4th saturating accept → sat_count=1.
